// File: rtl/eth_frame_echo_pkg.sv
// Shared definitions for the Ethernet frame echo responder.
// Holds the header geometry constants, the receive/transmit FSM state
// encoding and the saturating counter helper used by the top level.
package eth_frame_echo_pkg;

    localparam int MAC_HDR_LEN  = 14;
    localparam int MAC_ADDR_LEN = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2,
        SEND = 2'd3
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/eth_frame_echo_ram.sv
// Frame buffer: simple dual-port RAM, 8 bits x 2**ADDR_WIDTH.
// Ports:
//   clk             clock
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr   read request; rd_data is registered and holds while rd_en=0
//   rd_data         read data, valid one cycle after rd_en
module eth_frame_echo_ram #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data
);

    logic [7:0] mem_r [0:(1 << ADDR_WIDTH) - 1];
    logic [7:0] rd_data_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; the output holds its value when not enabled.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/eth_frame_echo.sv
// Ethernet frame echo: captures good rx_axis frames into a buffer and sends
// them back on tx_axis with dst MAC := original src MAC, src MAC := LOCAL_MAC.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   enable                    accept new frames when high
//   rx_axis_*                 receive stream (no backpressure), tuser = bad frame
//   tx_axis_*                 transmit stream, tuser always 0
//   busy                      a captured frame is being sent
//   frames_echoed/dropped     saturating event counters
module eth_frame_echo
    import eth_frame_echo_pkg::*;
#(
    parameter int          ADDR_WIDTH = 11,
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  rx_axis_tdata,
    input  logic        rx_axis_tvalid,
    input  logic        rx_axis_tlast,
    input  logic        rx_axis_tuser,
    output logic [7:0]  tx_axis_tdata,
    output logic        tx_axis_tvalid,
    input  logic        tx_axis_tready,
    output logic        tx_axis_tlast,
    output logic        tx_axis_tuser,
    output logic        busy,
    output logic [15:0] frames_echoed,
    output logic [15:0] frames_dropped
);

    // Lengths need one bit more than addresses to represent a full buffer.
    localparam int            LW          = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] ONE_W       = LW'(1);
    localparam logic [LW-1:0] HDR_W       = LW'(MAC_HDR_LEN);
    localparam logic [LW-1:0] MAC_OFF_W   = LW'(MAC_ADDR_LEN);
    localparam logic [LW-1:0] LAST_ADDR_W = LW'((1 << ADDR_WIDTH) - 1);

    state_t                state_r, state_next_s;
    logic                  in_frame_r, dt_active_r;
    logic [LW-1:0]         len_r, frame_len_r, rd_idx_r, pf_idx_r;
    logic                  pf_valid_r;
    logic [7:0]            tdata_r;
    logic                  tvalid_r, tlast_r, tuser_r, busy_r;
    logic [15:0]           echoed_r, dropped_r;

    logic                  first_beat_s, wr_en_s, main_drop_s, rd_en_s, load_out_s, done_s;
    logic                  dt_start_s, dt_drop_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s, rd_addr_s;
    logic [7:0]            rd_data_s, tx_byte_s;

    // A beat can only open a new frame when no frame is in flight on rx.
    assign first_beat_s = rx_axis_tvalid && !in_frame_r;

    eth_frame_echo_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (rx_axis_tdata),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                // Single-beat frames are runts and never leave IDLE.
                if (first_beat_s && !rx_axis_tlast) begin
                    state_next_s = enable ? RECV : DROP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RECV: begin
                if (rx_axis_tvalid && rx_axis_tlast) begin
                    if (!rx_axis_tuser && ((len_r + ONE_W) >= HDR_W)) begin
                        state_next_s = SEND;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else if (rx_axis_tvalid && (len_r == LAST_ADDR_W)) begin
                    state_next_s = DROP;
                end else begin
                    state_next_s = RECV;
                end
            end
            DROP: begin
                if (rx_axis_tvalid && rx_axis_tlast) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DROP;
                end
            end
            SEND: begin
                if (done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SEND;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Per-state datapath controls: buffer writes, drops, read prefetch, output load.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_addr_s   = {ADDR_WIDTH{1'b0}};
        main_drop_s = 1'b0;
        rd_en_s     = 1'b0;
        load_out_s  = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                wr_en_s     = first_beat_s && enable;
                main_drop_s = first_beat_s && rx_axis_tlast;
            end
            RECV: begin
                wr_en_s     = rx_axis_tvalid;
                wr_addr_s   = len_r[ADDR_WIDTH-1:0];
                main_drop_s = rx_axis_tvalid && rx_axis_tlast &&
                              (rx_axis_tuser || ((len_r + ONE_W) < HDR_W));
            end
            DROP: begin
                main_drop_s = rx_axis_tvalid && rx_axis_tlast;
            end
            SEND: begin
                // Output register refills from the prefetched RAM word whenever
                // it is empty or being consumed; the RAM refetches as soon as
                // the prefetch slot frees, sustaining one byte per cycle.
                load_out_s = pf_valid_r && (!tvalid_r || tx_axis_tready);
                rd_en_s    = (rd_idx_r < frame_len_r) && (!pf_valid_r || load_out_s);
                done_s     = tvalid_r && tx_axis_tready && tlast_r;
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Output bytes 0..5 come from the original source address (buffer 6..11).
    always_comb begin
        if (rd_idx_r < MAC_OFF_W) begin
            rd_addr_s = rd_idx_r[ADDR_WIDTH-1:0] + ADDR_WIDTH'(MAC_ADDR_LEN);
        end else begin
            rd_addr_s = rd_idx_r[ADDR_WIDTH-1:0];
        end
    end

    // Bytes 6..11 are replaced by LOCAL_MAC, most significant byte first.
    always_comb begin
        case (pf_idx_r)
            MAC_OFF_W + LW'(0): tx_byte_s = LOCAL_MAC[47:40];
            MAC_OFF_W + LW'(1): tx_byte_s = LOCAL_MAC[39:32];
            MAC_OFF_W + LW'(2): tx_byte_s = LOCAL_MAC[31:24];
            MAC_OFF_W + LW'(3): tx_byte_s = LOCAL_MAC[23:16];
            MAC_OFF_W + LW'(4): tx_byte_s = LOCAL_MAC[15:8];
            MAC_OFF_W + LW'(5): tx_byte_s = LOCAL_MAC[7:0];
            default:            tx_byte_s = rd_data_s;
        endcase
    end

    // Drop tracker: frames that open while SEND owns the buffer are counted
    // at their tlast, regardless of where the main FSM is by then.
    assign dt_start_s = first_beat_s && (state_r == SEND);
    assign dt_drop_s  = (dt_start_s && rx_axis_tlast) ||
                        (dt_active_r && rx_axis_tvalid && rx_axis_tlast);

    // Datapath registers: rx framing, capture length, prefetch, output stage, counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame_r  <= 1'b0;
            dt_active_r <= 1'b0;
            len_r       <= {LW{1'b0}};
            frame_len_r <= {LW{1'b0}};
            rd_idx_r    <= {LW{1'b0}};
            pf_idx_r    <= {LW{1'b0}};
            pf_valid_r  <= 1'b0;
            tdata_r     <= 8'h00;
            tvalid_r    <= 1'b0;
            tlast_r     <= 1'b0;
            tuser_r     <= 1'b0;
            busy_r      <= 1'b0;
            echoed_r    <= 16'h0000;
            dropped_r   <= 16'h0000;
        end else begin
            if (rx_axis_tvalid) begin
                in_frame_r <= !rx_axis_tlast;
            end

            if (dt_start_s && !rx_axis_tlast) begin
                dt_active_r <= 1'b1;
            end else if (dt_active_r && rx_axis_tvalid && rx_axis_tlast) begin
                dt_active_r <= 1'b0;
            end

            // In IDLE byte 0 goes to address 0, so RECV resumes at length 1.
            if (state_r == IDLE) begin
                len_r <= ONE_W;
            end else if ((state_r == RECV) && rx_axis_tvalid) begin
                len_r <= len_r + ONE_W;
            end

            if ((state_r == RECV) && (state_next_s == SEND)) begin
                frame_len_r <= len_r + ONE_W;
            end

            if (state_r != SEND) begin
                rd_idx_r   <= {LW{1'b0}};
                pf_valid_r <= 1'b0;
            end else if (rd_en_s) begin
                rd_idx_r   <= rd_idx_r + ONE_W;
                pf_idx_r   <= rd_idx_r;
                pf_valid_r <= 1'b1;
            end else if (load_out_s) begin
                pf_valid_r <= 1'b0;
            end

            if (done_s) begin
                tvalid_r <= 1'b0;
                tlast_r  <= 1'b0;
            end else if (load_out_s) begin
                tvalid_r <= 1'b1;
                tdata_r  <= tx_byte_s;
                tlast_r  <= (pf_idx_r == (frame_len_r - ONE_W));
            end

            tuser_r <= 1'b0;
            busy_r  <= (state_next_s == SEND);

            if (done_s) begin
                echoed_r <= sat_inc16(echoed_r);
            end
            if (main_drop_s || dt_drop_s) begin
                dropped_r <= sat_inc16(dropped_r);
            end
        end
    end

    assign tx_axis_tdata  = tdata_r;
    assign tx_axis_tvalid = tvalid_r;
    assign tx_axis_tlast  = tlast_r;
    assign tx_axis_tuser  = tuser_r;
    assign busy           = busy_r;
    assign frames_echoed  = echoed_r;
    assign frames_dropped = dropped_r;

endmodule

// File: tb/tb_eth_frame_echo.sv
// Directed testbench for eth_frame_echo: good echo, bad/runt/disabled/oversize
// drops, drops while sending, random backpressure, and reset mid-send.
module tb_eth_frame_echo;

    localparam int          AW   = 11;
    localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [7:0]  rx_tdata = 8'h00;
    logic        rx_tvalid = 1'b0;
    logic        rx_tlast = 1'b0;
    logic        rx_tuser = 1'b0;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready = 1'b1;
    logic        tx_tlast;
    logic        tx_tuser;
    logic        busy;
    logic [15:0] frames_echoed;
    logic [15:0] frames_dropped;

    always #4 clk = ~clk;

    eth_frame_echo #(.ADDR_WIDTH(AW), .LOCAL_MAC(LMAC)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .rx_axis_tdata  (rx_tdata),
        .rx_axis_tvalid (rx_tvalid),
        .rx_axis_tlast  (rx_tlast),
        .rx_axis_tuser  (rx_tuser),
        .tx_axis_tdata  (tx_tdata),
        .tx_axis_tvalid (tx_tvalid),
        .tx_axis_tready (tx_tready),
        .tx_axis_tlast  (tx_tlast),
        .tx_axis_tuser  (tx_tuser),
        .busy           (busy),
        .frames_echoed  (frames_echoed),
        .frames_dropped (frames_dropped)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] frame_buf [0:2099];
    logic [8:0] exp_q [$];
    logic [8:0] obs_q [$];
    int         tlast_cnt   = 0;
    int         busy_cycles = 0;
    int         stall_cnt   = 0;
    int         stall_errs  = 0;
    int         ready_mode  = 0;
    bit         stalled     = 1'b0;
    logic [8:0] hold_beat   = 9'h000;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // tready pattern: 0 = always ready, 1 = stalled, otherwise random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       tx_tready = 1'b1;
            1:       tx_tready = 1'b0;
            default: tx_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // tx monitor: records handshaken beats and checks hold-stability on stalls.
    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (stalled && tx_tvalid && !rst) begin
            stall_cnt++;
            if ({tx_tlast, tx_tdata} !== hold_beat) stall_errs++;
        end
        stalled   = tx_tvalid && !tx_tready;
        hold_beat = {tx_tlast, tx_tdata};
        if (tx_tvalid && tx_tready) begin
            obs_q.push_back({tx_tlast, tx_tdata});
            if (tx_tlast) tlast_cnt++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fill_frame(input int len, input int seed);
        for (int i = 0; i < len; i++) frame_buf[i] = 8'(i * 3 + seed);
    endtask

    // Expected echo: dst := src, src := LOCAL_MAC, rest unchanged.
    task automatic build_exp(input int len);
        logic [47:0] m;
        logic [7:0]  b;
        m = LMAC;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 6)       b = frame_buf[i + 6];
            else if (i < 12) b = m[47 - 8 * (i - 6) -: 8];
            else             b = frame_buf[i];
            exp_q.push_back({(i == len - 1), b});
        end
    endtask

    // Drives len beats from frame_buf; returns just after the tlast beat's edge.
    task automatic send_frame(input int len, input bit bad);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            rx_tvalid = 1'b1;
            rx_tdata  = frame_buf[i];
            rx_tlast  = (i == len - 1);
            rx_tuser  = bad && (i == len - 1);
        end
        @(posedge clk); #1;
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        rx_tuser  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int start_cnt, input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            if (tlast_cnt != start_cnt) break;
            @(negedge clk);
        end
        check_value({tag, "_done"}, 32'(tlast_cnt - start_cnt), 32'd1);
    endtask

    task automatic compare_stream(input string tag, input int base);
        int n;
        int errs;
        n    = obs_q.size() - base;
        errs = 0;
        check_value({tag, "_len"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            if (obs_q[base + i] !== exp_q[i]) errs++;
        end
        check_value({tag, "_bytes"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int base;
        int tc;
        int bc;

        do_reset();
        @(negedge clk);
        check_value("rst_tvalid", {31'd0, tx_tvalid}, 32'd0);
        check_value("rst_tlast",  {31'd0, tx_tlast},  32'd0);
        check_value("rst_tdata",  {24'd0, tx_tdata},  32'd0);
        check_value("rst_tuser",  {31'd0, tx_tuser},  32'd0);
        check_value("rst_busy",   {31'd0, busy},      32'd0);
        check_value("rst_echoed", {16'd0, frames_echoed},  32'd0);
        check_value("rst_dropped",{16'd0, frames_dropped}, 32'd0);

        // T1: 60-byte broadcast frame from 00:11:22:33:44:55.
        fill_frame(60, 17);
        for (int i = 0; i < 6; i++) frame_buf[i] = 8'hFF;
        frame_buf[6] = 8'h00; frame_buf[7]  = 8'h11; frame_buf[8]  = 8'h22;
        frame_buf[9] = 8'h33; frame_buf[10] = 8'h44; frame_buf[11] = 8'h55;
        build_exp(60);
        base = obs_q.size();
        tc   = tlast_cnt;
        send_frame(60, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_value("t1_tvalid_c1", {31'd0, tx_tvalid}, 32'd0);
        @(negedge clk);
        check_value("t1_tvalid_c2", {31'd0, tx_tvalid}, 32'd1);
        check_value("t1_byte0",     {24'd0, tx_tdata},  32'h00);
        check_value("t1_busy",      {31'd0, busy},      32'd1);
        wait_done("t1", tc, 200);
        @(negedge clk);
        compare_stream("t1", base);
        check_value("t1_echoed", {16'd0, frames_echoed}, 32'd1);
        check_value("t1_tvalid_end", {31'd0, tx_tvalid}, 32'd0);
        check_value("t1_busy_end",   {31'd0, busy},      32'd0);

        // T2: bad frame, disabled frame and runt are all dropped silently.
        do_reset();
        base = obs_q.size();
        bc   = busy_cycles;
        fill_frame(64, 5);
        send_frame(64, 1'b1);
        repeat (10) @(negedge clk);
        check_value("t2_dropped", {16'd0, frames_dropped}, 32'd1);
        check_value("t2_no_tx",   32'(obs_q.size() - base), 32'd0);
        check_value("t2_no_busy", 32'(busy_cycles - bc), 32'd0);
        enable = 1'b0;
        send_frame(20, 1'b0);
        enable = 1'b1;
        send_frame(1, 1'b0);
        repeat (10) @(negedge clk);
        check_value("t2_dropped3", {16'd0, frames_dropped}, 32'd3);
        check_value("t2_no_tx3",   32'(obs_q.size() - base), 32'd0);

        // T3: frame arriving while SEND is stalled is dropped.
        do_reset();
        ready_mode = 1;
        fill_frame(100, 40);
        build_exp(100);
        base = obs_q.size();
        tc   = tlast_cnt;
        send_frame(100, 1'b0);
        repeat (5) @(posedge clk);
        fill_frame(64, 99);
        send_frame(64, 1'b0);
        @(negedge clk);
        check_value("t3_drop_stalled", {16'd0, frames_dropped}, 32'd1);
        check_value("t3_tvalid_held",  {31'd0, tx_tvalid},      32'd1);
        ready_mode = 0;
        wait_done("t3", tc, 400);
        repeat (10) @(negedge clk);
        compare_stream("t3", base);
        check_value("t3_echoed",  {16'd0, frames_echoed},  32'd1);
        check_value("t3_dropped", {16'd0, frames_dropped}, 32'd1);

        // T4: 1514-byte echo under random backpressure.
        do_reset();
        fill_frame(1514, 201);
        build_exp(1514);
        base = obs_q.size();
        tc   = tlast_cnt;
        ready_mode = 2;
        send_frame(1514, 1'b0);
        wait_done("t4", tc, 20000);
        ready_mode = 0;
        repeat (4) @(negedge clk);
        compare_stream("t4", base);
        check_value("t4_stalls_seen", 32'(stall_cnt > 0), 32'd1);
        check_value("t4_stall_errs",  32'(stall_errs),    32'd0);
        check_value("t4_echoed",      {16'd0, frames_echoed}, 32'd1);

        // T5: oversize and short frames dropped; 14 and 2048 bytes echoed.
        do_reset();
        base = obs_q.size();
        fill_frame(2049, 9);
        send_frame(2049, 1'b0);
        fill_frame(13, 77);
        send_frame(13, 1'b0);
        repeat (10) @(negedge clk);
        check_value("t5_dropped", {16'd0, frames_dropped}, 32'd2);
        check_value("t5_no_tx",   32'(obs_q.size() - base), 32'd0);
        fill_frame(14, 123);
        build_exp(14);
        tc = tlast_cnt;
        send_frame(14, 1'b0);
        wait_done("t5_14", tc, 100);
        @(negedge clk);
        compare_stream("t5_14", base);
        fill_frame(2048, 61);
        build_exp(2048);
        base = obs_q.size();
        tc   = tlast_cnt;
        send_frame(2048, 1'b0);
        wait_done("t5_2048", tc, 5000);
        @(negedge clk);
        compare_stream("t5_2048", base);
        check_value("t5_echoed", {16'd0, frames_echoed}, 32'd2);

        // T6: reset in the middle of SEND, then a clean echo.
        do_reset();
        send_frame(1, 1'b0);
        fill_frame(60, 150);
        base = obs_q.size();
        tc   = tlast_cnt;
        send_frame(60, 1'b0);
        for (int c = 0; c < 200; c++) begin
            if (obs_q.size() - base >= 30) break;
            @(negedge clk);
        end
        check_value("t6_reached30", 32'(obs_q.size() - base >= 30), 32'd1);
        check_value("t6_pre_drop",  {16'd0, frames_dropped}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_value("t6_tvalid", {31'd0, tx_tvalid}, 32'd0);
        check_value("t6_echoed", {16'd0, frames_echoed},  32'd0);
        check_value("t6_dropped",{16'd0, frames_dropped}, 32'd0);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check_value("t6_no_tlast", 32'(tlast_cnt - tc), 32'd0);
        fill_frame(60, 33);
        build_exp(60);
        base = obs_q.size();
        tc   = tlast_cnt;
        send_frame(60, 1'b0);
        wait_done("t6b", tc, 200);
        @(negedge clk);
        compare_stream("t6b", base);
        check_value("t6b_echoed", {16'd0, frames_echoed}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_frame_echo.md
Name: eth_frame_echo

Overview:
- Host-side responder on the MAC's AXI-stream pair: consumes rx_axis frames and returns each good frame on tx_axis.
- Destination MAC becomes the original source MAC; source MAC becomes LOCAL_MAC.
- Sits next to the RGMII MAC/FIFO wrapper for link bring-up and loopback testing.
- The RX side has no tready, so a frame that arrives while the buffer is occupied is dropped and counted.

Parameters:
ADDR_WIDTH, 11, frame buffer depth 2**ADDR_WIDTH bytes (max frame length accepted)
LOCAL_MAC, 48'h02_00_00_00_00_01, source MAC inserted in echoed frames (byte 6 = MSB)

Ports:
clk  in  1  single clock (125 MHz logic clock)
rst  in  1  synchronous reset, active-high
enable  in  1  accept new frames when high
rx_axis_tdata  in  8  received byte
rx_axis_tvalid  in  1  byte valid (always accepted)
rx_axis_tlast  in  1  last byte of frame
rx_axis_tuser  in  1  bad-frame flag, sampled with tlast
tx_axis_tdata  out  8  echoed byte
tx_axis_tvalid  out  1  byte valid
tx_axis_tready  in  1  MAC ready
tx_axis_tlast  out  1  last byte of echoed frame
tx_axis_tuser  out  1  always 0
busy  out  1  buffer holds or is sending a frame
frames_echoed  out  16  saturating count of frames fully sent
frames_dropped  out  16  saturating count of dropped frames

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: tx_axis_tvalid=0, tx_axis_tlast=0, tx_axis_tdata=0, tx_axis_tuser=0, busy=0, both counters=0, state IDLE, in_frame=0.
- in_frame flag: set on any rx beat without tlast, cleared on a tlast beat. A capture may only start on a beat where in_frame=0. A frame already in progress when IDLE is entered is ignored until it ends, and is not counted.
- IDLE: an rx beat with in_frame=0 and enable=1 writes byte 0 at address 0 and goes to RECV. If enable=0, go to DROP instead. A single-beat frame (tlast on first beat) is a runt: drop and count.
- RECV: each beat writes buffer[len], len++.
- If len reaches 2**ADDR_WIDTH before tlast, go to DROP (oversize).
- On tlast with tuser=1, or final length < 14: count drop, go to IDLE.
- On tlast with tuser=0 and length 14..2**ADDR_WIDTH: latch length L, go to SEND.
- DROP: discard beats; on tlast, frames_dropped++ and go to IDLE.
- SEND: busy=1. Frame RAM has 1-cycle registered read; the output stage is a one-entry register plus RAM prefetch.
- tx_axis_tvalid first rises 2 cycles after the accepting rx tlast cycle.
- Output byte i is:
  - buffer[i+6] for i=0..5;
  - LOCAL_MAC byte (i-6), MSB first, for i=6..11;
  - buffer[i] for i>=12.
- tlast asserts on byte L-1. Exactly L bytes are sent.
- tdata, tlast and tvalid hold stable while tvalid=1 and tready=0. One byte per cycle is sustained when tready=1.
- On the L-1 handshake: frames_echoed++, tvalid=0 next cycle, state IDLE, busy=0.
- Any rx frame that starts during SEND is dropped and counted at its tlast, tracked by a parallel drop-tracker independent of the main FSM.
- Simultaneous events: a drop-tracker tlast and the SEND completion in the same cycle both increment their counters. An rx first beat in the completion cycle counts as arriving during SEND and is dropped.
- Counters saturate at 16'hFFFF.
- rst mid-SEND: tvalid=0 on the next cycle, frame abandoned with no tlast, counters cleared.
- enable deasserted mid-RECV or mid-SEND does not affect the current frame.

Decomposition:
- eth_frame_echo_pkg: MAC_HDR_LEN=14, MAC_ADDR_LEN=6, state enum {IDLE, RECV, DROP, SEND}.
- Sub-module eth_frame_echo_ram: simple dual-port RAM, 8 bits x 2**ADDR_WIDTH, write port plus registered read port with read enable.

Test Plan:
- 60-byte good frame, dst=FF:FF:FF:FF:FF:FF, src=00:11:22:33:44:55, tready=1 → 60 bytes out. Bytes 0-5 = 00:11:22:33:44:55; bytes 6-11 = 02:00:00:00:00:01; bytes 12-59 identical to input; tlast on byte 59; first tvalid 2 cycles after rx tlast; frames_echoed=1.
- 64-byte frame with tuser=1 on tlast → no tx activity; frames_dropped=1; busy stays 0.
- Good 100-byte frame, then a 64-byte frame starting while SEND is stalled by tready=0 → only the 100-byte frame is echoed; frames_dropped=1, frames_echoed=1.
- tready toggled in a pseudo-random pattern during a 1514-byte echo → output byte stream exact; tdata stable on every stall; no bytes lost or duplicated.
- 2049-byte frame with ADDR_WIDTH=11, then a 13-byte frame → both dropped, frames_dropped=2, no tx. A following 14-byte frame is echoed.
- rst asserted at byte 30 of a 60-byte SEND → tvalid=0 next cycle; counters=0. A fresh 60-byte frame afterwards is echoed correctly.
